fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 129 ++++++++++++
 tb/tb_fetch_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one instruction-memory read at a time,
// captures the returned word into ir, and hands it to the consumer with a
// valid/ready handshake. A redirect restarts fetching from a new address from
// any state. A halt opcode parks the sequencer until the next redirect.
// ir[15:12] is taken as the opcode, so DATA_W must be at least 16.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DATA_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]        HALT_OPCODE = 4'b1111
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic              busy,
  output logic [15:0]       instr_count
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    HALT
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
  logic                ir_valid_q, ir_valid_d;
  logic [15:0]         count_q, count_d;
  logic                imem_en_q, imem_en_d;
  logic                halted_q, halted_d;
  logic                busy_q, busy_d;

  // Next-state and datapath: redirect overrides every state and the handshake.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    count_d    = count_q;
    if (redirect) begin
      state_d    = ISSUE;
      pc_d       = redirect_pc;
      ir_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ISSUE;
            pc_d    = RESET_PC;
          end
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          ir_d       = imem_data;
          ir_pc_d    = pc_q;
          pc_d       = pc_q + ADDR_W'(1);
          ir_valid_d = 1'b1;
          state_d    = HOLD;
        end
        HOLD: begin
          if (ir_ready) begin
            ir_valid_d = 1'b0;
            count_d    = count_q + 16'd1;
            state_d    = (ir_q[15:12] == HALT_OPCODE) ? HALT : ISSUE;
          end
        end
        HALT: state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs are registered, decoded from the state being entered.
  always_comb begin
    imem_en_d = (state_d == ISSUE);
    busy_d    = (state_d == ISSUE) || (state_d == WAIT) || (state_d == HOLD);
    halted_d  = (state_d == HALT);
  end

  // FSM state, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      count_q    <= '0;
      imem_en_q  <= 1'b0;
      halted_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      count_q    <= count_d;
      imem_en_q  <= imem_en_d;
      halted_q   <= halted_d;
      busy_q     <= busy_d;
    end
  end

  assign imem_en     = imem_en_q;
  assign imem_addr   = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign halted      = halted_q;
  assign busy        = busy_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed vector table, hand-written corner
// sequences and a randomized run checked against a delivery-order model.
module tb_fetch_sequencer;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;
  logic        busy;
  logic [15:0] instr_count;

  logic [15:0] mem [0:65535];

  int n_total = 0;
  int n_pass  = 0;

  fetch_sequencer #(
    .ADDR_W(16),
    .DATA_W(16),
    .RESET_PC(16'h0000),
    .HALT_OPCODE(4'b1111)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .ir(ir),
    .ir_pc(ir_pc),
    .ir_valid(ir_valid),
    .ir_ready(ir_ready),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .halted(halted),
    .busy(busy),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: data valid the cycle after imem_en.
  always @(posedge clk) begin
    if (imem_en) imem_data <= mem[imem_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic        rdy;
    logic        en;
    logic [15:0] addr;
    logic        val;
    logic [15:0] ir;
    logic [15:0] irpc;
    logic        busy;
    logic        halt;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"},    imem_en, 0);
    chk({tag, "_addr"},  imem_addr, 0);
    chk({tag, "_ir"},    ir, 0);
    chk({tag, "_irpc"},  ir_pc, 0);
    chk({tag, "_valid"}, ir_valid, 0);
    chk({tag, "_halt"},  halted, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_cnt"},   instr_count, 0);
  endtask

  task automatic do_reset();
    start = 0; redirect = 0; redirect_pc = 0; ir_ready = 0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  // Waits (bounded) for ir_valid, sampled on falling edges.
  task automatic wait_valid(input string tag);
    int unsigned k;
    k = 0;
    while (!ir_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, ir_valid, 1);
  endtask

  // One clock with the current inputs, leaving us on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int unsigned gap;
  logic [15:0] exp_pc;
  logic [15:0] exp_cnt;

  initial begin
    reset_n = 0; start = 0; redirect = 0; redirect_pc = 0; ir_ready = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[0] = 16'h5104;
    mem[1] = 16'h5205;
    mem[2] = 16'hF000;

    //            st rdy en addr     val ir        irpc     busy halt cnt
    vecs.push_back('{H, H, H, 16'd0, L, 16'h0000, 16'd0, H, L, 16'd0});
    vecs.push_back('{L, H, L, 16'd0, L, 16'h0000, 16'd0, H, L, 16'd0});
    vecs.push_back('{L, H, L, 16'd1, H, 16'h5104, 16'd0, H, L, 16'd0});
    vecs.push_back('{L, H, H, 16'd1, L, 16'h5104, 16'd0, H, L, 16'd1});
    vecs.push_back('{L, H, L, 16'd1, L, 16'h5104, 16'd0, H, L, 16'd1});
    vecs.push_back('{L, H, L, 16'd2, H, 16'h5205, 16'd1, H, L, 16'd1});
    vecs.push_back('{L, H, H, 16'd2, L, 16'h5205, 16'd1, H, L, 16'd2});
    vecs.push_back('{L, L, L, 16'd2, L, 16'h5205, 16'd1, H, L, 16'd2});
    for (int i = 0; i < 6; i++)
      vecs.push_back('{L, L, L, 16'd3, H, 16'hF000, 16'd2, H, L, 16'd2});
    vecs.push_back('{L, H, L, 16'd3, L, 16'hF000, 16'd2, L, H, 16'd3});
    vecs.push_back('{H, H, L, 16'd3, L, 16'hF000, 16'd2, L, H, 16'd3});

    // Reset state and idling without start.
    do_reset();
    chk_reset_outputs("rst");
    repeat (3) step();
    chk("idle_en", imem_en, 0);
    chk("idle_busy", busy, 0);

    // Directed table: nominal flow, stall in HOLD, halt, start ignored.
    foreach (vecs[i]) begin
      start    = vecs[i].st;
      ir_ready = vecs[i].rdy;
      step();
      chk($sformatf("v%0d_en", i),    imem_en,     vecs[i].en);
      chk($sformatf("v%0d_addr", i),  imem_addr,   vecs[i].addr);
      chk($sformatf("v%0d_valid", i), ir_valid,    vecs[i].val);
      chk($sformatf("v%0d_ir", i),    ir,          vecs[i].ir);
      chk($sformatf("v%0d_irpc", i),  ir_pc,       vecs[i].irpc);
      chk($sformatf("v%0d_busy", i),  busy,        vecs[i].busy);
      chk($sformatf("v%0d_halt", i),  halted,      vecs[i].halt);
      chk($sformatf("v%0d_cnt", i),   instr_count, vecs[i].cnt);
    end
    start = 0;

    // Parked in HALT: no fetches.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_en", imem_en, 0);
      chk("halt_flag", halted, 1);
      chk("halt_busy", busy, 0);
    end

    // Redirect out of HALT to address 0.
    redirect = 1; redirect_pc = 16'h0000;
    step();
    redirect = 0;
    chk("rdh_en", imem_en, 1);
    chk("rdh_addr", imem_addr, 16'h0000);
    chk("rdh_halt", halted, 0);
    chk("rdh_busy", busy, 1);
    ir_ready = 0;
    wait_valid("rdh");
    chk("rdh_irpc", ir_pc, 16'h0000);
    chk("rdh_ir", ir, 16'h5104);
    chk("rdh_cnt", instr_count, 3);

    // Redirect during WAIT: stale word must never reach ir.
    do_reset();
    mem[16'h0010] = 16'h3A10;
    start = 1;
    step();
    start = 0;
    step();                       // now in WAIT for address 0
    chk("rw_wait_en", imem_en, 0);
    redirect = 1; redirect_pc = 16'h0010;
    step();
    redirect = 0;
    chk("rw_en", imem_en, 1);
    chk("rw_addr", imem_addr, 16'h0010);
    for (int i = 0; i < 2; i++) begin
      chk("rw_nostale", ir, 16'h0000);
      chk("rw_novalid", ir_valid, 0);
      step();
    end
    wait_valid("rw");
    chk("rw_irpc", ir_pc, 16'h0010);
    chk("rw_ir", ir, 16'h3A10);

    // Redirect in HOLD with ready high: not counted; then wrap past FFFF.
    mem[16'hFFFF] = 16'h1234;
    ir_ready = 1; redirect = 1; redirect_pc = 16'hFFFF;
    step();
    redirect = 0; ir_ready = 0;
    chk("rh_cnt", instr_count, 0);
    chk("rh_addr", imem_addr, 16'hFFFF);
    wait_valid("wrap1");
    chk("wrap1_irpc", ir_pc, 16'hFFFF);
    chk("wrap1_ir", ir, 16'h1234);
    ir_ready = 1;
    step();
    ir_ready = 0;
    chk("wrap_cnt", instr_count, 1);
    wait_valid("wrap2");
    chk("wrap2_irpc", ir_pc, 16'h0000);
    chk("wrap2_ir", ir, 16'h5104);

    // Asynchronous reset mid-WAIT, then restart.
    do_reset();
    start = 1;
    step();
    start = 0;
    @(posedge clk);               // enter WAIT
    #2 reset_n = 0;
    #1 chk_reset_outputs("arst");
    @(negedge clk);
    reset_n = 1;
    repeat (3) begin
      step();
      chk("arst_idle_en", imem_en, 0);
      chk("arst_idle_valid", ir_valid, 0);
    end
    start = 1;
    step();
    start = 0;
    chk("arst_en", imem_en, 1);
    chk("arst_addr", imem_addr, 16'h0000);
    wait_valid("arst");
    chk("arst_irpc", ir_pc, 16'h0000);
    chk("arst_ir", ir, 16'h5104);

    // Randomized run: delivered instructions must follow sequential order from
    // the last redirect target, each word matching memory; count = accepts.
    for (int i = 0; i < 65536; i++)
      mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    do_reset();
    exp_pc = 16'h0000;
    exp_cnt = 16'h0000;
    gap = 0;
    start = 1;
    step();
    start = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      chk("rnd_cnt", instr_count, exp_cnt);
      chk("rnd_halt", halted, 0);
      chk("rnd_busy", busy, 1);
      if (imem_en) chk("rnd_addr", imem_addr, exp_pc);
      if (ir_valid) begin
        chk("rnd_irpc", ir_pc, exp_pc);
        chk("rnd_ir", ir, mem[exp_pc]);
        gap = 0;
      end else begin
        gap++;
      end
      chk("rnd_gap", gap <= 2, 1);
      ir_ready    = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 16'($urandom);
      if (redirect) begin
        exp_pc = redirect_pc;
        gap = 0;
      end else if (ir_valid && ir_ready) begin
        exp_pc++;
        exp_cnt++;
      end
      step();
    end
    redirect = 0; ir_ready = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
